// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes on both sides.
// One trial subtraction per cycle; divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] next_r;
  logic             last_iter;

  // The full partial remainder is shifted in, so trial stays exact even when
  // the divisor uses the top bit; R < divisor keeps diff's sign bit meaningful.
  assign trial     = {r_reg, q_reg[WIDTH-1]};
  assign diff      = trial + ~{1'b0, div_reg} + ONE;
  assign last_iter = (count == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    next_q = {q_reg[WIDTH-2:0], 1'b0};
    next_r = trial[WIDTH-1:0];
    if (!diff[WIDTH]) begin
      next_q = {q_reg[WIDTH-2:0], 1'b1};
      next_r = diff[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_reg <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              q_reg <= dividend;
              r_reg <= '0;
              count <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          q_reg <= next_q;
          r_reg <= next_r;
          count <= count + CW'(1);
          if (last_iter) begin
            quotient    <= next_q;
            remainder   <= next_r;
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: expected results are queued at accept
// from a behavioural / and % model and popped when the divider presents a result.
module tb_seq_restoring_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;
  int   failed = 0;
  bit   scramble = 1'b0;
  int   cycles;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one operation, wait (bounded) for acceptance and queue the model result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    sb.push_back(e);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic waitResult(output int c);
    c = 0;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1; c++;
      if (scramble) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    if (!out_valid) check("result_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"}, 64'(quotient), 64'(e.q));
      check({tag, "_r"}, 64'(remainder), 64'(e.r));
      check({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
    end
  endtask

  task automatic handOff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int bad;
    logic [W-1:0] held_q;
    logic [W-1:0] held_r;

    // 1. reset values, then 100/7 with exact latency
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'd100, 32'd7, 1'b0);
    waitResult(cycles);
    check("lat_100_7", 64'(cycles), 64'd32);
    checkOutput("div_100_7");
    handOff("div_100_7");

    // 2. extreme and mid-range operands
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0);
    waitResult(cycles);
    checkOutput("div_max_1");
    handOff("div_max_1");
    applyStimulus(32'd1412430746, 32'd439314084, 1'b0);
    waitResult(cycles);
    checkOutput("div_mid");
    handOff("div_mid");
    applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    waitResult(cycles);
    checkOutput("div_top_bit");
    handOff("div_top_bit");

    // 3. dividend < divisor, then divide by zero lands in DONE on the accept edge
    applyStimulus(32'd7, 32'd100, 1'b0);
    waitResult(cycles);
    checkOutput("div_7_100");
    handOff("div_7_100");
    applyStimulus(32'd5, 32'd0, 1'b0);
    check("dz_immediate_valid", 64'(out_valid), 64'd1);
    waitResult(cycles);
    checkOutput("div_5_0");

    // 4. backpressure: outputs held while out_ready stays low
    held_q = quotient;
    held_r = remainder;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || quotient !== held_q || remainder !== held_r || !div_by_zero) bad++;
    end
    check("backpressure_stable", 64'(bad), 64'd0);
    handOff("backpressure");

    // 5. in_valid held high with scrambled operands while BUSY, then back-to-back
    scramble = 1'b1;
    applyStimulus(32'd100, 32'd7, 1'b1);
    waitResult(cycles);
    scramble = 1'b0;
    check("hold_lat", 64'(cycles), 64'd32);
    check("hold_in_ready_done", 64'(in_ready), 64'd0);
    checkOutput("hold_100_7");
    dividend  = 32'd503031402;
    divisor   = 32'd3;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_not_accepted", 64'(in_ready), 64'd1);
    applyStimulus(32'd503031402, 32'd3, 1'b0);
    waitResult(cycles);
    check("b2b_lat", 64'(cycles), 64'd32);
    checkOutput("b2b_503031402_3");
    handOff("b2b");

    // 6. reset mid-operation aborts, then a fresh operation completes
    applyStimulus(32'd1953138822, 32'd65536, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_quotient", 64'(quotient), 64'd0);
    check("abort_remainder", 64'(remainder), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("abort_no_result", 64'(bad), 64'd0);
    applyStimulus(32'd1953138822, 32'd65536, 1'b0);
    waitResult(cycles);
    checkOutput("post_reset");
    handOff("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
